// File: rtl/div_if.sv
// div_if: request/response handshake between the EXE stage and the divide unit
interface div_if #(parameter int DIV_W = 32);
    logic             div_valid;
    logic             div_ready;
    logic [1:0]       div_op;
    logic [DIV_W-1:0] div_src1;
    logic [DIV_W-1:0] div_src2;
    logic             res_valid;
    logic             res_ready;
    logic [DIV_W-1:0] res_data;
    logic             flush;
    logic             div_busy;
    modport master (
        output div_valid, div_op, div_src1, div_src2, res_ready, flush,
        input  div_ready, res_valid, res_data, div_busy
    );
    modport slave (
        input  div_valid, div_op, div_src1, div_src2, res_ready, flush,
        output div_ready, res_valid, res_data, div_busy
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips iteration and goes straight to DONE.
module div_sequencer #(
    parameter int DIV_W = 32,
    parameter int CNT_W = 6
) (
    input logic   clk,
    input logic   resetn,
    div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_W);
    state_t           state, state_n;
    logic [1:0]       op_q;
    logic             s1_neg, s2_neg;
    logic [DIV_W-1:0] dvd, dvs, rem, res_q;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W:0]   trial;
    logic [DIV_W-1:0] abs1, abs2, quo_fix, rem_fix;
    logic             accept, fast_zero;
    // the shifted partial remainder is W+1 bits wide; the top bit of the difference is the borrow
    assign trial   = {rem, dvd[DIV_W-1]} - {1'b0, dvs};
    assign abs1    = (~bus.div_op[1] & bus.div_src1[DIV_W-1]) ? -bus.div_src1 : bus.div_src1;
    assign abs2    = (~bus.div_op[1] & bus.div_src2[DIV_W-1]) ? -bus.div_src2 : bus.div_src2;
    assign quo_fix = (s1_neg ^ s2_neg) ? -dvd : dvd;
    assign rem_fix = s1_neg ? -rem : rem;
    assign accept  = state == IDLE && bus.div_valid && !bus.flush;
`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = bus.div_src2 == '0;
`else
    assign fast_zero = 1'b0;
`endif
    assign bus.div_ready = state == IDLE;
    assign bus.div_busy  = state != IDLE;
    assign bus.res_valid = state == DONE;
    assign bus.res_data  = res_q;
    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end
    // next state: flush wins over every other event
    always_comb begin
        state_n = state;
        state_n = bus.flush ? IDLE :
                  state == IDLE ? (bus.div_valid ? (fast_zero ? DONE : BUSY) : IDLE) :
                  state == BUSY ? (cnt == LAST ? DONE : BUSY) :
                  (bus.res_ready ? IDLE : DONE);
    end
    // operand latch, one restoring step per BUSY cycle, sign fix on the extra final cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            s1_neg <= 1'b0;
            s2_neg <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            res_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.div_op;
            s1_neg <= ~bus.div_op[1] & bus.div_src1[DIV_W-1];
            s2_neg <= ~bus.div_op[1] & bus.div_src2[DIV_W-1];
            dvd    <= abs1;
            dvs    <= abs2;
            rem    <= '0;
            cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (fast_zero)
                res_q <= bus.div_op[0] ? bus.div_src1 :
                         (~bus.div_op[1] & bus.div_src1[DIV_W-1]) ? DIV_W'(1) : '1;
`endif
        end else if (state == BUSY && !bus.flush) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                res_q <= op_q[0] ? rem_fix : quo_fix;
            end else begin
                dvd <= {dvd[DIV_W-2:0], ~trial[DIV_W]};
                rem <= trial[DIV_W] ? {rem[DIV_W-2:0], dvd[DIV_W-1]} : trial[DIV_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors for div_sequencer with hand-computed results
module tb_div_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int total = 0;
    int bad = 0;
    int zlat;
    int n;
    logic seen;
    logic [31:0] d0;
    always #5 clk = ~clk;
    div_if #(.DIV_W(32)) bus();
    div_sequencer #(.DIV_W(32), .CNT_W(6)) dut (.clk(clk), .resetn(resetn), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.div_op = op;
        bus.div_src1 = a;
        bus.div_src2 = b;
        bus.div_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        bus.div_op = ~op;
        bus.div_src1 = $urandom;
        bus.div_src2 = $urandom;
    endtask
    task automatic wait_res(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.res_valid && cycles < 100);
    endtask
    task automatic consume(input string tag);
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, bus.res_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, bus.div_ready}, 32'd1);
    endtask
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int c;
        issue(op, a, b);
        wait_res(c);
        check({tag, "_lat"}, c, lat);
        check(tag, bus.res_data, exp);
        consume(tag);
    endtask
    task automatic watch_idle(input int cycles, output logic hit);
        hit = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) hit = 1'b1;
        end
    endtask
    initial begin
`ifdef DIV_ZERO_FAST_EN
        zlat = 1;
`else
        zlat = 33;
`endif
        bus.div_valid = 1'b0;
        bus.div_op = 2'b00;
        bus.div_src1 = '0;
        bus.div_src2 = '0;
        bus.res_ready = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_ready", {31'b0, bus.div_ready}, 32'd1);
        check("rst_busy", {31'b0, bus.div_busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("divwu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33);
        run_op("modwu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("divw_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("modw_m7_2", 2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("divw_7_m2", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("modw_7_m2", 2'b01, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
        run_op("divw_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        run_op("modw_ovf", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
        run_op("divwu_max_10", 2'b10, 32'hFFFFFFFF, 32'd10, 32'h19999999, 33);
        run_op("modwu_max_10", 2'b11, 32'hFFFFFFFF, 32'd10, 32'd5, 33);
        run_op("divwu_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, zlat);
        run_op("modwu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, zlat);
        run_op("divw_m5_0", 2'b00, 32'hFFFFFFFB, 32'd0, 32'd1, zlat);
        run_op("modw_m5_0", 2'b01, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, zlat);
        run_op("divw_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, zlat);
        // flush mid-BUSY
        issue(2'b10, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", {31'b0, bus.div_busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_valid", {31'b0, bus.res_valid}, 32'd0);
        check("flush_ready", {31'b0, bus.div_ready}, 32'd1);
        check("flush_busy", {31'b0, bus.div_busy}, 32'd0);
        watch_idle(40, seen);
        check("flush_no_result", {31'b0, seen}, 32'd0);
        run_op("after_flush", 2'b10, 32'd1000, 32'd3, 32'd333, 33);
        // flush together with a request in IDLE is not accepted
        @(negedge clk);
        bus.div_valid = 1'b1;
        bus.flush = 1'b1;
        bus.div_op = 2'b10;
        bus.div_src2 = 32'd1;
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        bus.flush = 1'b0;
        check("flush_idle_busy", {31'b0, bus.div_busy}, 32'd0);
        watch_idle(40, seen);
        check("flush_idle_no_result", {31'b0, seen}, 32'd0);
        // DONE stall with res_ready low and a competing request
        issue(2'b10, 32'd1000, 32'd10);
        wait_res(n);
        check("stall_lat", n, 33);
        d0 = bus.res_data;
        check("stall_data", d0, 32'd100);
        @(negedge clk);
        bus.div_valid = 1'b1;
        bus.div_op = 2'b11;
        bus.div_src1 = 32'd77;
        bus.div_src2 = 32'd5;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'b0, bus.res_valid}, 32'd1);
            check("stall_hold", bus.res_data, 32'd100);
            check("stall_ready", {31'b0, bus.div_ready}, 32'd0);
        end
        @(negedge clk);
        bus.div_valid = 1'b0;
        consume("stall");
        // async reset mid-BUSY
        issue(2'b10, 32'd50, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", {31'b0, bus.res_valid}, 32'd0);
        check("arst_data", bus.res_data, 32'd0);
        check("arst_ready", {31'b0, bus.div_ready}, 32'd1);
        check("arst_busy", {31'b0, bus.div_busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        watch_idle(40, seen);
        check("arst_no_result", {31'b0, seen}, 32'd0);
        run_op("after_reset", 2'b10, 32'd50, 32'd7, 32'd7, 33);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
